// File: rtl/error_analyzer.sv
// Receive-side error analyzer: Hamming distance of ref/rx chunk pairs accumulated over a window of WIN chunks.
// Optional ERR_POS_EN adds err_pos, a sticky OR of every flip pattern seen in the window.
module error_analyzer #(
   parameter int N   = 3,
   parameter int WIN = 16,
   parameter int CW  = 16
) (
   input  logic                     clk,
   input  logic                     reset,
   input  logic                     start,
   input  logic [N-1:0]             ref_in,
   input  logic [N-1:0]             rx_in,
   input  logic                     in_valid,
   output logic                     in_ready,
   output logic                     busy,
   output logic                     done,
   output logic [CW-1:0]            err_bits,
   output logic [CW-1:0]            err_chunks,
   output logic [$clog2(N+1)-1:0]   max_err,
   output logic                     sat
`ifdef ERR_POS_EN
   ,
   output logic [N-1:0]             err_pos
`endif
);

   localparam int MW = $clog2(N+1);
   localparam int KW = $clog2(WIN+1);

   localparam logic [1:0] S_IDLE    = 2'd0;
   localparam logic [1:0] S_MEASURE = 2'd1;
   localparam logic [1:0] S_DRAIN   = 2'd2;
   localparam logic [1:0] S_DONE    = 2'd3;

   logic [1:0]    state_q, state_d;
   logic [KW-1:0] cnt_q, cnt_d;
   logic          v1_q, v1_d;
   logic [MW-1:0] pc_q, pc_d, pc_new;
   logic [CW-1:0] bits_q, bits_d;
   logic [CW-1:0] chunks_q, chunks_d;
   logic [MW-1:0] max_q, max_d;
   logic          sat_q, sat_d;
   logic          xfer;
   logic          start_go;
   logic [CW:0]   bits_sum;
   logic [CW:0]   chunks_sum;

   assign in_ready = (state_q == S_MEASURE) && (cnt_q < KW'(WIN));
   assign busy     = (state_q == S_MEASURE) || (state_q == S_DRAIN);
   assign done     = (state_q == S_DONE);
   assign xfer     = in_valid & in_ready;
   assign start_go = start && ((state_q == S_IDLE) || (state_q == S_DONE));

   assign err_bits   = bits_q;
   assign err_chunks = chunks_q;
   assign max_err    = max_q;
   assign sat        = sat_q;

   always_comb begin
      pc_new = '0;
      for (int unsigned i = 0; i < N; i++) begin
         pc_new = pc_new + MW'(ref_in[i] ^ rx_in[i]);
      end
   end

   // One extra bit on each sum exposes the overflow used for saturation.
   assign bits_sum   = {1'b0, bits_q}   + (CW+1)'(pc_q);
   assign chunks_sum = {1'b0, chunks_q} + (CW+1)'(pc_q != '0);

   always_comb begin
      state_d  = state_q;
      cnt_d    = cnt_q;
      v1_d     = xfer;
      pc_d     = xfer ? pc_new : pc_q;
      bits_d   = bits_q;
      chunks_d = chunks_q;
      max_d    = max_q;
      sat_d    = sat_q;

      if (v1_q) begin
         if (bits_sum[CW]) begin
            bits_d = '1;
            sat_d  = 1'b1;
         end else begin
            bits_d = bits_sum[CW-1:0];
         end
         if (chunks_sum[CW]) begin
            chunks_d = '1;
            sat_d    = 1'b1;
         end else begin
            chunks_d = chunks_sum[CW-1:0];
         end
         if (pc_q > max_q) begin
            max_d = pc_q;
         end
      end

      case (state_q)
         S_MEASURE: begin
            if (xfer) begin
               cnt_d = cnt_q + 1'b1;
               if (cnt_q == KW'(WIN-1)) begin
                  state_d = S_DRAIN;
               end
            end
         end
         S_DRAIN: state_d = S_DONE;
         S_DONE:  state_d = S_IDLE;
         default: state_d = S_IDLE;
      endcase

      if (start_go) begin
         state_d  = S_MEASURE;
         cnt_d    = '0;
         v1_d     = 1'b0;
         bits_d   = '0;
         chunks_d = '0;
         max_d    = '0;
         sat_d    = 1'b0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         state_q  <= S_IDLE;
         cnt_q    <= '0;
         v1_q     <= 1'b0;
         pc_q     <= '0;
         bits_q   <= '0;
         chunks_q <= '0;
         max_q    <= '0;
         sat_q    <= 1'b0;
      end else begin
         state_q  <= state_d;
         cnt_q    <= cnt_d;
         v1_q     <= v1_d;
         pc_q     <= pc_d;
         bits_q   <= bits_d;
         chunks_q <= chunks_d;
         max_q    <= max_d;
         sat_q    <= sat_d;
      end
   end

`ifdef ERR_POS_EN
   logic [N-1:0] d_q, d_d;
   logic [N-1:0] pos_q, pos_d;

   always_comb begin
      d_d   = xfer ? (ref_in ^ rx_in) : d_q;
      pos_d = pos_q;
      if (v1_q) begin
         pos_d = pos_q | d_q;
      end
      if (start_go) begin
         pos_d = '0;
      end
   end

   always_ff @(posedge clk) begin
      if (!reset) begin
         d_q   <= '0;
         pos_q <= '0;
      end else begin
         d_q   <= d_d;
         pos_q <= pos_d;
      end
   end

   assign err_pos = pos_q;
`endif

endmodule

// File: tb/tb_error_analyzer.sv
// Self-checking bench for error_analyzer: two instances (CW=16 and CW=3, both N=3, WIN=4) share stimulus.
// Expected results come from a per-window list of pairs reduced with plain arithmetic.
module tb_error_analyzer;

   localparam int N   = 3;
   localparam int WIN = 4;

   logic         clk = 1'b0;
   logic         reset = 1'b0;
   logic         start = 1'b0;
   logic         in_valid = 1'b0;
   logic [N-1:0] ref_in = '0;
   logic [N-1:0] rx_in = '0;

   logic         in_ready_a, busy_a, done_a, sat_a;
   logic [15:0]  err_bits_a, err_chunks_a;
   logic [1:0]   max_err_a;
   logic         in_ready_b, busy_b, done_b, sat_b;
   logic [2:0]   err_bits_b, err_chunks_b;
   logic [1:0]   max_err_b;
`ifdef ERR_POS_EN
   logic [N-1:0] err_pos_a, err_pos_b;
`endif

   int tests = 0;
   int fails = 0;

   logic [N-1:0] wr [WIN];
   logic [N-1:0] wx [WIN];

   error_analyzer #(.N(N), .WIN(WIN), .CW(16)) dut_a (
      .clk(clk), .reset(reset), .start(start), .ref_in(ref_in), .rx_in(rx_in),
      .in_valid(in_valid), .in_ready(in_ready_a), .busy(busy_a), .done(done_a),
      .err_bits(err_bits_a), .err_chunks(err_chunks_a), .max_err(max_err_a), .sat(sat_a)
`ifdef ERR_POS_EN
      , .err_pos(err_pos_a)
`endif
   );

   error_analyzer #(.N(N), .WIN(WIN), .CW(3)) dut_b (
      .clk(clk), .reset(reset), .start(start), .ref_in(ref_in), .rx_in(rx_in),
      .in_valid(in_valid), .in_ready(in_ready_b), .busy(busy_b), .done(done_b),
      .err_bits(err_bits_b), .err_chunks(err_chunks_b), .max_err(max_err_b), .sat(sat_b)
`ifdef ERR_POS_EN
      , .err_pos(err_pos_b)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      tests++;
      assert (obs === exp)
      else begin
         fails++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic chk_zero(input string tag);
      chk({tag, " in_ready"}, 32'(in_ready_a), 0);
      chk({tag, " busy"},     32'(busy_a), 0);
      chk({tag, " done"},     32'(done_a), 0);
      chk({tag, " sat"},      32'(sat_a), 0);
      chk({tag, " bits"},     32'(err_bits_a), 0);
      chk({tag, " chunks"},   32'(err_chunks_a), 0);
      chk({tag, " max"},      32'(max_err_a), 0);
      chk({tag, " bits_b"},   32'(err_bits_b), 0);
`ifdef ERR_POS_EN
      chk({tag, " pos"},      32'(err_pos_a), 0);
`endif
   endtask

   // Window reference: sum/count/max of popcounts, then clamp at each counter width.
   task automatic check_results(input string tag);
      int sum = 0;
      int ch = 0;
      int mx = 0;
      logic [N-1:0] pos = '0;
      for (int i = 0; i < WIN; i++) begin
         int p = $countones(wr[i] ^ wx[i]);
         sum += p;
         if (p != 0) ch++;
         if (p > mx) mx = p;
         pos |= wr[i] ^ wx[i];
      end
      chk({tag, " bits_a"},   32'(err_bits_a),   (sum > 65535) ? 65535 : sum);
      chk({tag, " chunks_a"}, 32'(err_chunks_a), (ch > 65535) ? 65535 : ch);
      chk({tag, " max_a"},    32'(max_err_a),    mx);
      chk({tag, " sat_a"},    32'(sat_a),        (sum > 65535 || ch > 65535) ? 1 : 0);
      chk({tag, " bits_b"},   32'(err_bits_b),   (sum > 7) ? 7 : sum);
      chk({tag, " chunks_b"}, 32'(err_chunks_b), (ch > 7) ? 7 : ch);
      chk({tag, " max_b"},    32'(max_err_b),    mx);
      chk({tag, " sat_b"},    32'(sat_b),        (sum > 7 || ch > 7) ? 1 : 0);
`ifdef ERR_POS_EN
      chk({tag, " pos_a"},    32'(err_pos_a),    32'(pos));
      chk({tag, " pos_b"},    32'(err_pos_b),    32'(pos));
`endif
   endtask

   task automatic run_window(input string tag, input int gap, input bit poke);
      start = 1'b1;
      tick();
      start = 1'b0;
      chk({tag, " busy after start"},     32'(busy_a), 1);
      chk({tag, " in_ready after start"}, 32'(in_ready_a), 1);
      chk({tag, " bits cleared"},         32'(err_bits_a), 0);
      chk({tag, " sat cleared"},          32'(sat_b), 0);
`ifdef ERR_POS_EN
      chk({tag, " pos cleared"},          32'(err_pos_a), 0);
`endif
      for (int i = 0; i < WIN; i++) begin
         ref_in   = wr[i];
         rx_in    = wx[i];
         in_valid = 1'b1;
         tick();
         in_valid = 1'b0;
         ref_in   = N'($urandom);
         rx_in    = N'($urandom);
         if (i == 0) chk({tag, " bits not yet updated"}, 32'(err_bits_a), 0);
         if (i == 1 && poke) begin
            start = 1'b1;
            tick();
            start = 1'b0;
         end
         if (i < WIN - 1) begin
            for (int g = 0; g < gap; g++) begin
               chk({tag, " in_ready in gap"}, 32'(in_ready_a), 1);
               tick();
            end
         end
      end
      chk({tag, " in_ready after last"}, 32'(in_ready_a), 0);
      chk({tag, " busy in drain"},       32'(busy_a), 1);
      chk({tag, " done early"},          32'(done_a), 0);
      in_valid = 1'b1;
      tick();
      chk({tag, " done"},        32'(done_a), 1);
      chk({tag, " done_b"},      32'(done_b), 1);
      chk({tag, " busy in done"}, 32'(busy_a), 0);
      check_results(tag);
      tick();
      in_valid = 1'b0;
      chk({tag, " done one cycle"}, 32'(done_a), 0);
      chk({tag, " in_ready idle"},  32'(in_ready_a), 0);
      check_results({tag, " held"});
   endtask

   initial begin
      tick();
      chk_zero("reset");
      tick();
      reset = 1'b1;
      tick();
      chk_zero("post reset");

      for (int i = 0; i < WIN; i++) begin wr[i] = 3'b101; wx[i] = 3'b101; end
      run_window("clean", 0, 1'b0);

      for (int i = 0; i < WIN; i++) begin wr[i] = 3'b000; wx[i] = 3'b111; end
      run_window("allflip", 0, 1'b1);

      wr[0] = 3'b010; wx[0] = 3'b011;
      wr[1] = 3'b110; wx[1] = 3'b110;
      wr[2] = 3'b001; wx[2] = 3'b111;
      wr[3] = 3'b100; wx[3] = 3'b100;
      run_window("gaps", 3, 1'b0);

      start = 1'b1;
      tick();
      start = 1'b0;
      for (int i = 0; i < 2; i++) begin
         ref_in = 3'b000; rx_in = 3'b011; in_valid = 1'b1;
         tick();
      end
      in_valid = 1'b0;
      reset = 1'b0;
      tick();
      chk_zero("mid reset");
      tick();
      reset = 1'b1;
      tick();
      chk_zero("after mid reset");
      for (int i = 0; i < WIN; i++) begin wr[i] = N'($urandom); wx[i] = wr[i] ^ 3'b010; end
      run_window("fresh", 1, 1'b0);

      wr[0] = 3'b000; wx[0] = 3'b001;
      wr[1] = 3'b000; wx[1] = 3'b100;
      wr[2] = 3'b011; wx[2] = 3'b011;
      wr[3] = 3'b110; wx[3] = 3'b110;
      run_window("pos", 0, 1'b0);

      for (int w = 0; w < 20; w++) begin
         for (int i = 0; i < WIN; i++) begin
            wr[i] = N'($urandom);
            wx[i] = ($urandom_range(0, 3) == 0) ? wr[i] : N'($urandom);
         end
         run_window("random", int'($urandom_range(0, 3)), bit'($urandom_range(0, 1)));
      end

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
